// File: rtl/gate_truth_sweeper.sv
// Built-in self-test stage for a 2-input gate: drives all four {a,b} vectors,
// lets each one settle, samples y and records mismatches against a truth table.
module gate_truth_sweeper #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECTED      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [1:0] vec_idx
);

  localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          miss_s;
  logic [3:0]    mask_next_s;

  // Error mask as it will look once the current vector's verdict is merged in
  always_comb begin
    miss_s               = (y != EXPECTED[vec_idx]);
    mask_next_s          = err_mask;
    mask_next_s[vec_idx] = miss_s;
  end

  // Sweep sequencer; every output is a register so a, b never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      vec_idx  <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          a       <= 1'b0;
          b       <= 1'b0;
          vec_idx <= 2'd0;
          busy    <= 1'b0;
          if (start) begin
            cnt_r    <= '0;
            err_mask <= 4'b0000;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state_r  <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_mask <= mask_next_s;
          if (vec_idx == 2'd3) begin
            // pass must already include the vector-3 verdict during DONE
            pass    <= ~|mask_next_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            vec_idx <= vec_idx + 2'd1;
            {a, b}  <= vec_idx + 2'd1;
            cnt_r   <= '0;
            state_r <= SETTLE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          a       <= 1'b0;
          b       <= 1'b0;
          vec_idx <= 2'd0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          a       <= 1'b0;
          b       <= 1'b0;
          vec_idx <= 2'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: two instances (default and SETTLE_CYCLES=1/XOR)
// each wired to a table-driven gate model, checked cycle by cycle.
module tb_gate_truth_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sel;
  logic [3:0] tbl0, tbl1;
  int         n_tests, n_fail;

  logic       a0, b0, busy0, done0, pass0, y0;
  logic       a1, b1, busy1, done1, pass1, y1;
  logic [3:0] em0, em1;
  logic [1:0] vi0, vi1;

  assign y0 = tbl0[{a0, b0}];
  assign y1 = tbl1[{a1, b1}];

  gate_truth_sweeper dut0 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .y(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_mask(em0), .vec_idx(vi0)
  );

  gate_truth_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(em1), .vec_idx(vi1)
  );

  // Outputs of whichever instance is currently under test
  logic       oa, ob, obusy, odone, opass;
  logic [3:0] oem;
  logic [1:0] ovi;
  assign oa    = sel ? a1 : a0;
  assign ob    = sel ? b1 : b0;
  assign obusy = sel ? busy1 : busy0;
  assign odone = sel ? done1 : done0;
  assign opass = sel ? pass1 : pass0;
  assign oem   = sel ? em1 : em0;
  assign ovi   = sel ? vi1 : vi0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ab"}, {30'd0, oa, ob}, 32'd0);
    check_eq({tag, "_vec"}, {30'd0, ovi}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, obusy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, odone}, 32'd0);
    check_eq({tag, "_pass"}, {31'd0, opass}, 32'd0);
    check_eq({tag, "_mask"}, {28'd0, oem}, 32'd0);
  endtask

  // One sweep on the selected instance. Called at a negedge with the DUT in IDLE.
  // pulse_k: cycle index where start is re-pulsed; noise: random start pulses;
  // abort_k: cycle index where reset is asserted; hold: keep start high through DONE.
  task automatic sweep(input int s, input logic [3:0] tbl, input logic [3:0] expv,
                       input int pulse_k, input bit noise, input int abort_k, input bit hold);
    int         total;
    int         v;
    logic [3:0] exp_m;
    total = 4 * (s + 1);
    if (sel) tbl1 = tbl; else tbl0 = tbl;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < total; k++) begin
      v = k / (s + 1);
      exp_m = 4'b0000;
      for (int vv = 0; vv < 4; vv++)
        if ((vv + 1) * (s + 1) <= k) exp_m[vv] = tbl[vv] ^ expv[vv];
      check_eq("vec_idx", {30'd0, ovi}, v);
      check_eq("ab", {30'd0, oa, ob}, v);
      check_eq("busy", {31'd0, obusy}, 32'd1);
      check_eq("done_early", {31'd0, odone}, 32'd0);
      check_eq("mask_progress", {28'd0, oem}, {28'd0, exp_m});
      if (k == 0) check_eq("pass_cleared", {31'd0, opass}, 32'd0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      start = (k == pulse_k) || (noise && ($urandom_range(0, 3) == 0));
      @(negedge clk);
    end
    check_eq("done", {31'd0, odone}, 32'd1);
    check_eq("busy_in_done", {31'd0, obusy}, 32'd1);
    check_eq("vec_in_done", {30'd0, ovi}, 32'd3);
    check_eq("err_mask", {28'd0, oem}, {28'd0, tbl ^ expv});
    check_eq("pass", {31'd0, opass}, {31'd0, (tbl == expv)});
    start = hold;
    @(negedge clk);
    check_eq("idle_done", {31'd0, odone}, 32'd0);
    check_eq("idle_busy", {31'd0, obusy}, 32'd0);
    check_eq("idle_ab", {30'd0, oa, ob}, 32'd0);
    check_eq("idle_vec", {30'd0, ovi}, 32'd0);
    check_eq("held_mask", {28'd0, oem}, {28'd0, tbl ^ expv});
    check_eq("held_pass", {31'd0, opass}, {31'd0, (tbl == expv)});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    tbl0    = 4'b1110;
    tbl1    = 4'b0110;
    repeat (2) @(negedge clk);
    check_zero("reset0");
    sel = 1'b1;
    #1;
    check_zero("reset1");
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    sweep(2, 4'b1110, 4'b1110, -1, 1'b0, -1, 1'b0);  // OR gate
    sweep(2, 4'b1000, 4'b1110, -1, 1'b0, -1, 1'b0);  // AND gate
    sweep(2, 4'b1111, 4'b1110, -1, 1'b0, -1, 1'b0);  // y stuck at 1
    sweep(2, 4'b1110, 4'b1110, 3, 1'b0, -1, 1'b0);   // start re-pulsed in vector 1
    sweep(2, 4'b1000, 4'b1110, -1, 1'b0, 7, 1'b0);   // reset during vector 2
    check_zero("after_reset");
    sweep(2, 4'b1110, 4'b1110, -1, 1'b0, -1, 1'b0);

    sel = 1'b1;
    @(negedge clk);
    sweep(1, 4'b0110, 4'b0110, -1, 1'b0, -1, 1'b1);  // XOR, back-to-back
    sweep(1, 4'b0110, 4'b0110, -1, 1'b0, -1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      start = 1'b0;
      sel = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if (sel)
        sweep(1, 4'($urandom_range(0, 15)), 4'b0110, -1, 1'b1, -1, 1'b0);
      else
        sweep(2, 4'($urandom_range(0, 15)), 4'b1110, -1, 1'b1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
